// File: rtl/lsu_mem_initiator.sv
// ============================================================================
// Module   : lsu_mem_initiator
// Purpose  : Load/store initiator between the execute stage and a byte-
//            addressed big-endian data memory. One request at a time over a
//            valid/ready handshake, response returned over valid/ready.
// Options  : LSU_MISALIGN_SPLIT_EN - when defined, misaligned word accesses
//            are split into four byte accesses; otherwise they are rejected
//            with RespError=1 and never touch memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_initiator #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ReqValid,
  output logic                     ReqReady,
  input  logic                     ReqWrite,
  input  logic                     ReqByte,
  input  logic                     ReqSigned,
  input  logic [ADDRESS_WIDTH-1:0] ReqAddress,
  input  logic [DATA_WIDTH-1:0]    ReqWriteData,
  output logic                     RespValid,
  input  logic                     RespReady,
  output logic [DATA_WIDTH-1:0]    RespData,
  output logic                     RespError,
  output logic                     MemWE,
  output logic                     MemByteOp,
  output logic [ADDRESS_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0]    MemWriteData,
  input  logic [DATA_WIDTH-1:0]    MemReadData
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ACCESS   = 2'd1;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic [1:0] S_BYTE_SEQ = 2'd2;
`endif
  localparam logic [1:0] S_RESP     = 2'd3;

  logic [1:0]               r_state;
  logic [1:0]               w_next_state;
  logic                     r_ready_en;
  logic                     r_write;
  logic                     r_byte;
  logic                     r_signed;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH-1:0]    r_result;
  logic                     r_error;

  logic                     w_accept;
  logic                     w_misaligned;
  logic [DATA_WIDTH-1:0]    w_load_value;

  // A word access is misaligned when either low address bit is set
  assign w_misaligned = !ReqByte && (ReqAddress[1:0] != 2'b00);
  assign w_accept     = ReqValid && ReqReady;

  // Byte loads are sign- or zero-extended from lane [7:0]; word loads pass through
  assign w_load_value = r_byte ?
      {{(DATA_WIDTH-BYTE_WIDTH){r_signed & MemReadData[BYTE_WIDTH-1]}},
       MemReadData[BYTE_WIDTH-1:0]} :
      MemReadData;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [1:0]               r_k;
  logic [31:0]              w_lane_shift;
  logic [DATA_WIDTH-1:0]    w_wdata_shifted;
  logic [BYTE_WIDTH-1:0]    w_lane_out;
  logic [DATA_WIDTH-1:0]    w_lane_in;

  // Byte k of a split access maps to bits [31-8k -: 8] (big-endian)
  assign w_lane_shift    = BYTE_WIDTH * {30'd0, r_k};
  assign w_wdata_shifted = r_wdata << w_lane_shift;
  assign w_lane_out      = w_wdata_shifted[DATA_WIDTH-1 -: BYTE_WIDTH];
  assign w_lane_in       = {MemReadData[BYTE_WIDTH-1:0],
                            {(DATA_WIDTH-BYTE_WIDTH){1'b0}}} >> w_lane_shift;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          w_next_state = w_misaligned ? S_BYTE_SEQ : S_ACCESS;
`else
          w_next_state = w_misaligned ? S_RESP : S_ACCESS;
`endif
        end
      end
      S_ACCESS: w_next_state = S_RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
      S_BYTE_SEQ: if (r_k == 2'd3) w_next_state = S_RESP;
`endif
      S_RESP: if (RespReady) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Hold ReqReady low during reset and for the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ready_en <= 1'b0;
    else        r_ready_en <= 1'b1;
  end

  // Request capture, read-data latching and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write  <= 1'b0;
      r_byte   <= 1'b0;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_result <= '0;
      r_error  <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_k      <= 2'd0;
`endif
    end else begin
      if (w_accept) begin
        r_write  <= ReqWrite;
        r_byte   <= ReqByte;
        r_signed <= ReqSigned;
        r_addr   <= ReqAddress;
        r_wdata  <= ReqWriteData;
        r_result <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
        r_error  <= 1'b0;
        r_k      <= 2'd0;
`else
        r_error  <= w_misaligned;
`endif
      end
      if (r_state == S_ACCESS && !r_write) begin
        r_result <= w_load_value;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      if (r_state == S_BYTE_SEQ) begin
        r_k <= r_k + 2'd1;
        if (!r_write) r_result <= r_result | w_lane_in;
      end
`endif
    end
  end

  // Output decode; memory signals are forced to zero outside access states
  always_comb begin
    ReqReady     = 1'b0;
    RespValid    = 1'b0;
    RespData     = '0;
    RespError    = 1'b0;
    MemWE        = 1'b0;
    MemByteOp    = 1'b0;
    MemAddress   = '0;
    MemWriteData = '0;
    case (r_state)
      S_IDLE: ReqReady = r_ready_en;
      S_ACCESS: begin
        MemWE        = r_write;
        MemByteOp    = r_byte;
        MemAddress   = r_addr;
        MemWriteData = r_wdata;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_BYTE_SEQ: begin
        MemWE        = r_write;
        MemByteOp    = 1'b1;
        MemAddress   = r_addr + {{(ADDRESS_WIDTH-2){1'b0}}, r_k};
        MemWriteData = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, w_lane_out};
      end
`endif
      S_RESP: begin
        RespValid = 1'b1;
        RespData  = r_result;
        RespError = r_error;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
// ============================================================================
// Module   : tb_lsu_mem_initiator
// Purpose  : Self-checking bench for lsu_mem_initiator with a big-endian
//            byte memory model. Honours LSU_MISALIGN_SPLIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ReqValid, ReqReady, ReqWrite, ReqByte, ReqSigned;
  logic [31:0] ReqAddress, ReqWriteData;
  logic        RespValid, RespReady, RespError;
  logic [31:0] RespData;
  logic        MemWE, MemByteOp;
  logic [31:0] MemAddress, MemWriteData, MemReadData;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .BYTE_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqByte(ReqByte), .ReqSigned(ReqSigned), .ReqAddress(ReqAddress),
    .ReqWriteData(ReqWriteData),
    .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData),
    .RespError(RespError),
    .MemWE(MemWE), .MemByteOp(MemByteOp), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .MemReadData(MemReadData)
  );

  // ---------------- memory model ----------------
  logic [7:0]  mem [logic [31:0]];
  int          mem_ver = 0;
  logic [31:0] wlog [$];

  function automatic logic [7:0] gb(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  function automatic logic [31:0] gw(input logic [31:0] a);
    return {gb(a), gb(a + 32'd1), gb(a + 32'd2), gb(a + 32'd3)};
  endfunction

  always @(MemAddress or MemByteOp or mem_ver) begin
    if (MemByteOp) MemReadData = {24'd0, gb(MemAddress)};
    else           MemReadData = gw(MemAddress);
  end

  always @(posedge clk) begin
    if (MemWE) begin
      if (MemByteOp) begin
        mem[MemAddress] = MemWriteData[7:0];
        wlog.push_back(MemAddress);
      end else begin
        mem[MemAddress]         = MemWriteData[31:24];
        mem[MemAddress + 32'd1] = MemWriteData[23:16];
        mem[MemAddress + 32'd2] = MemWriteData[15:8];
        mem[MemAddress + 32'd3] = MemWriteData[7:0];
      end
      mem_ver = mem_ver + 1;
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        byt;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
    int          exp_act;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic byt, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] ed, input logic ee,
                              input int el, input int ew, input int ea);
    vec_t v;
    v.wr = wr; v.byt = byt; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_data = ed; v.exp_err = ee; v.exp_lat = el; v.exp_we = ew; v.exp_act = ea;
    return v;
  endfunction

  function automatic logic [31:0] outs_or;
    return {31'd0, ReqReady | RespValid | RespError | MemWE | MemByteOp} |
           RespData | MemAddress | MemWriteData;
  endfunction

  // Wait for ReqReady, present one request and complete the accept edge
  task automatic issue(input vec_t v);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!ReqReady && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!ReqReady) check("req_ready_timeout", 32'd0, 32'd1);
    ReqWrite = v.wr; ReqByte = v.byt; ReqSigned = v.sgn;
    ReqAddress = v.addr; ReqWriteData = v.wdata; ReqValid = 1'b1;
    @(posedge clk);
    #1 ReqValid = 1'b0;
  endtask

  // Count cycles after the accept edge until RespValid, tallying memory activity
  task automatic wait_resp(output int lat, output int we, output int act);
    lat = 0; we = 0; act = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (RespValid) begin
        lat = c;
        break;
      end
      if (MemWE) we++;
      if (MemWE || MemByteOp || MemAddress != 0 || MemWriteData != 0) act++;
    end
    if (lat == 0) check("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_req(input vec_t v, input string tag);
    int lat, we, act;
    logic [31:0] d;
    logic e;
    issue(v);
    wait_resp(lat, we, act);
    d = RespData;
    e = RespError;
    if (lat != 0) begin
      RespReady = 1'b1;
      @(posedge clk);
      #1 RespReady = 1'b0;
    end
    check({tag, "_data"}, d, v.exp_data);
    check({tag, "_err"}, {31'd0, e}, {31'd0, v.exp_err});
    check({tag, "_lat"}, lat, v.exp_lat);
    check({tag, "_we"}, we, v.exp_we);
    check({tag, "_act"}, act, v.exp_act);
  endtask

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0] = mk(1, 0, 0, 32'h0001_0000, 32'hDEAD_BEEF, 32'h0, 0, 2, 1, 1);
    vecs[1] = mk(0, 0, 0, 32'h0001_0000, 32'h0,        32'hDEAD_BEEF, 0, 2, 0, 1);
    vecs[2] = mk(0, 1, 1, 32'h0001_0000, 32'h0,        32'hFFFF_FFDE, 0, 2, 0, 1);
    vecs[3] = mk(0, 1, 0, 32'h0001_0000, 32'h0,        32'h0000_00DE, 0, 2, 0, 1);
    vecs[4] = mk(1, 1, 0, 32'h0001_0003, 32'h1234_5655, 32'h0, 0, 2, 1, 1);
    vecs[5] = mk(0, 0, 0, 32'h0001_0000, 32'h0,        32'hDEAD_BE55, 0, 2, 0, 1);
    vecs[6] = mk(1, 0, 0, 32'h0001_0000, 32'hDEAD_BEEF, 32'h0, 0, 2, 1, 1);
    vecs[7] = mk(1, 1, 0, 32'h0001_0004, 32'h0000_0012, 32'h0, 0, 2, 1, 1);
`ifdef LSU_MISALIGN_SPLIT_EN
    vecs[8] = mk(0, 0, 0, 32'h0001_0001, 32'h0,        32'hADBE_EF12, 0, 5, 0, 4);
`else
    vecs[8] = mk(0, 0, 0, 32'h0001_0001, 32'h0,        32'h0, 1, 1, 0, 0);
`endif

    rst_n = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqByte = 1'b0;
    ReqSigned = 1'b0; ReqAddress = '0; ReqWriteData = '0; RespReady = 1'b0;

    // Reset state and ReqReady rising one edge after release
    repeat (2) @(negedge clk);
    check("reset_outputs", outs_or(), 32'd0);
    rst_n = 1'b1;
    #1 check("ready_before_edge", {31'd0, ReqReady}, 32'd0);
    @(posedge clk);
    #1 check("ready_after_edge", {31'd0, ReqReady}, 32'd1);

    // Table vectors 0..5
    for (int i = 0; i < 6; i++) run_req(vecs[i], $sformatf("v%0d", i));

    // Backpressure: response held for three cycles, stray requests ignored
    v = mk(0, 0, 0, 32'h0001_0000, 32'h0, 32'hDEAD_BE55, 0, 2, 0, 1);
    begin
      int lat, we, act;
      issue(v);
      wait_resp(lat, we, act);
      for (int c = 0; c < 3; c++) begin
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqByte = 1'b0;
        ReqAddress = 32'h0001_0000; ReqWriteData = 32'h0;
        @(negedge clk);
        check("bp_valid", {31'd0, RespValid}, 32'd1);
        check("bp_data", RespData, 32'hDEAD_BE55);
        check("bp_ready", {31'd0, ReqReady}, 32'd0);
        check("bp_we", {31'd0, MemWE}, 32'd0);
      end
      ReqValid = 1'b0;
      RespReady = 1'b1;
      @(posedge clk);
      #1 RespReady = 1'b0;
      @(negedge clk);
      check("bp_valid_drop", {31'd0, RespValid}, 32'd0);
      check("bp_ready_back", {31'd0, ReqReady}, 32'd1);
      check("bp_mem_intact", gw(32'h0001_0000), 32'hDEAD_BE55);
    end

    // Table vectors 6..8: rebuild DE AD BE EF 12, then misaligned load
    for (int i = 6; i < 9; i++) run_req(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of an access
`ifdef LSU_MISALIGN_SPLIT_EN
    mem[32'h0001_0007] = 8'h77;
    mem_ver++;
    v = mk(1, 0, 0, 32'h0001_0005, 32'hA1B2_C3D4, 32'h0, 0, 5, 4, 4);
    issue(v);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 check("rst_mid_outputs", outs_or(), 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_b5", {24'd0, gb(32'h0001_0005)}, 32'h0000_00A1);
    check("rst_mid_b6", {24'd0, gb(32'h0001_0006)}, 32'h0000_00B2);
    check("rst_mid_b7", {24'd0, gb(32'h0001_0007)}, 32'h0000_0077);
`else
    for (int b = 8; b < 12; b++) mem[32'h0001_0000 + b] = 8'h77;
    mem_ver++;
    v = mk(1, 0, 0, 32'h0001_0008, 32'h1122_3344, 32'h0, 0, 2, 1, 1);
    issue(v);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("rst_mid_outputs", outs_or(), 32'd0);
    @(posedge clk);
    #1 check("rst_mid_word", gw(32'h0001_0008), 32'h7777_7777);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("rst_no_resp", {31'd0, RespValid}, 32'd0);
    run_req(mk(0, 0, 0, 32'h0001_0000, 32'h0, 32'hDEAD_BEEF, 0, 2, 0, 1), "post_rst");

    // Address wrap on a misaligned word store
    wlog.delete();
`ifdef LSU_MISALIGN_SPLIT_EN
    run_req(mk(1, 0, 0, 32'hFFFF_FFFE, 32'h0102_0304, 32'h0, 0, 5, 4, 4), "wrap");
    check("wrap_nwr", wlog.size(), 32'd4);
    if (wlog.size() == 4) begin
      check("wrap_a0", wlog[0], 32'hFFFF_FFFE);
      check("wrap_a1", wlog[1], 32'hFFFF_FFFF);
      check("wrap_a2", wlog[2], 32'h0000_0000);
      check("wrap_a3", wlog[3], 32'h0000_0001);
    end
    check("wrap_hi", {gb(32'hFFFF_FFFE), gb(32'hFFFF_FFFF), 16'd0}, 32'h0102_0000);
    check("wrap_lo", {16'd0, gb(32'h0000_0000), gb(32'h0000_0001)}, 32'h0000_0304);
`else
    run_req(mk(1, 0, 0, 32'hFFFF_FFFE, 32'h0102_0304, 32'h0, 1, 1, 0, 0), "wrap");
    check("wrap_nwr", wlog.size(), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
